// File: rtl/ahb_trace_pkg.sv
// Shared AHB encodings and the trace record layout for the AHB trace capture block.
package ahb_trace_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int ATTR_W = 14;

  typedef struct packed {
    logic [31:0]       addr;
    logic [31:0]       data;
    logic [ATTR_W-1:0] attr;
    logic [31:0]       ts;
  } trace_rec_t;

  localparam int REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO holding trace records; a push into a full FIFO
// is accepted when a pop happens in the same cycle.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         pop_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic         push_ok, pop_ok;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign push_ok = push_i & (~full_o | pop_i);
  assign pop_ok  = pop_i & ~empty_o;

  // Output forced to zero when empty so the record bus never shows stale or unwritten entries.
  assign rd_data_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop_ok)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/ahb_trace_capture.sv
// Passive AHB-Lite snooper: pairs address and data phases into trace records and buffers them.
// Optional macro TRACE_TIMESTAMP_EN adds a cycle-count timestamp to every record.
module ahb_trace_capture
  import ahb_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              cap_en,
  input  logic              skip_zero,
  input  logic [31:0]       haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [3:0]        hprot,
  input  logic [31:0]       hwdata,
  input  logic [31:0]       hrdata,
  input  logic              hready,
  input  logic              hresp,
  output logic              tr_valid,
  input  logic              tr_ready,
  output logic [31:0]       tr_addr,
  output logic [31:0]       tr_data,
  output logic [13:0]       tr_attr,
  output logic [31:0]       tr_ts,
  output logic              ovf,
  output logic [CNT_W-1:0]  drop_cnt,
  input  logic              clr
);

`ifdef TRACE_TIMESTAMP_EN
  localparam int FIFO_W = REC_W;
`else
  localparam int FIFO_W = REC_W - 32;
`endif

  logic              accept, push, pop, drop;
  logic              fifo_full, fifo_empty;
  logic              pend_q, pend_d;
  logic [31:0]       addr_q, addr_d;
  logic [ATTR_W-2:0] ahi_q, ahi_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rec_data;
  logic [ATTR_W-1:0] rec_attr;
  logic [FIFO_W-1:0] wr_data, rd_data;
  trace_rec_t        rd_rec;

  assign accept = hready & ((htrans == HTRANS_NONSEQ) | (htrans == HTRANS_SEQ)) & cap_en
                & ~(skip_zero & (haddr == 32'h0));
  assign push   = pend_q & hready;
  assign pop    = ~fifo_empty & tr_ready;
  assign drop   = push & fifo_full & ~pop;

  assign rec_data = ahi_q[ATTR_W-2] ? hwdata : hrdata;
  assign rec_attr = {ahi_q, (hresp == HRESP_ERROR)};

  // Wait states hold the pending address phase; any hready=1 cycle retires it and may reload it.
  always_comb begin
    pend_d = pend_q;
    addr_d = addr_q;
    ahi_d  = ahi_q;
    if (hready) begin
      pend_d = accept;
      if (accept) begin
        addr_d = haddr;
        ahi_d  = {hwrite, hsize, hburst, hprot, htrans};
      end
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (clr) begin
      ovf_d = 1'b0;
      cnt_d = '0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pend_q <= 1'b0;
      addr_q <= '0;
      ahi_q  <= '0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      addr_q <= addr_d;
      ahi_q  <= ahi_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] ts_cnt_q, pts_q, pts_d;

  assign pts_d = accept ? ts_cnt_q : pts_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ts_cnt_q <= '0;
      pts_q    <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 32'd1;
      pts_q    <= pts_d;
    end
  end

  assign wr_data = {addr_q, rec_data, rec_attr, pts_q};
  assign rd_rec  = rd_data;
`else
  assign wr_data = {addr_q, rec_data, rec_attr};
  assign rd_rec  = {rd_data, 32'h0};
`endif

  trace_fifo #(
    .DEPTH (DEPTH),
    .W     (FIFO_W)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (rst_b),
    .push_i    (push),
    .wr_data_i (wr_data),
    .pop_i     (pop),
    .rd_data_o (rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign tr_valid = ~fifo_empty;
  assign tr_addr  = rd_rec.addr;
  assign tr_data  = rd_rec.data;
  assign tr_attr  = rd_rec.attr;
  assign tr_ts    = rd_rec.ts;
  assign ovf      = ovf_q;
  assign drop_cnt = cnt_q;

endmodule

// File: tb/tb_ahb_trace_capture.sv
// Scoreboard bench for ahb_trace_capture: transaction-level model of bus transfers and record queue.
module tb_ahb_trace_capture;

  localparam int DEPTH = 16;
  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        cap_en = 1'b1, skip_zero = 1'b0;
  logic [31:0] haddr = '0, hwdata = '0, hrdata = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0, hready = 1'b1, hresp = 1'b0;
  logic [2:0]  hsize = 3'd2, hburst = 3'd0;
  logic [3:0]  hprot = 4'h3;
  logic        tr_ready = 1'b1, clr = 1'b0;
  logic        tr_valid, ovf;
  logic [31:0] tr_addr, tr_data, tr_ts;
  logic [13:0] tr_attr;
  logic [CNT_W-1:0] drop_cnt;

  ahb_trace_capture #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_b(rst_b), .cap_en(cap_en), .skip_zero(skip_zero),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hprot(hprot), .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp),
    .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_addr(tr_addr), .tr_data(tr_data),
    .tr_attr(tr_attr), .tr_ts(tr_ts), .ovf(ovf), .drop_cnt(drop_cnt), .clr(clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [13:0] attr;
    logic [31:0] ts;
  } rec_t;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [12:0] info;
    logic [31:0] ts;
  } phase_t;

  rec_t   exp_q[$];
  phase_t outst_q[$];
  int     n_cmp = 0, n_bad = 0;
  int     n_popped = 0;
  int     m_drops = 0;
  logic   m_ovf = 1'b0;
  int unsigned m_cyc = 0;
  logic [31:0] last_addr_act = '0, last_data_act = '0;
  logic [13:0] last_attr_act = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor compares what the DUT shows, then the model advances to the coming clock edge.
  always @(negedge clk) begin
    if (!rst_b) begin
      check("reset_tr_valid", 64'(tr_valid), 64'(1'b0));
      check("reset_tr_addr", 64'(tr_addr), 64'(32'h0));
      check("reset_ovf", 64'(ovf), 64'(1'b0));
      check("reset_drop_cnt", 64'(drop_cnt), 64'(16'h0));
      exp_q.delete();
      outst_q.delete();
      m_drops = 0;
      m_ovf = 1'b0;
      m_cyc = 0;
    end else begin
      int  occ;
      logic do_pop;
      occ = exp_q.size();
      check("tr_valid", 64'(tr_valid), 64'(occ > 0));
      if (occ > 0 && tr_valid) begin
        check("tr_addr", 64'(tr_addr), 64'(exp_q[0].addr));
        check("tr_data", 64'(tr_data), 64'(exp_q[0].data));
        check("tr_attr", 64'(tr_attr), 64'(exp_q[0].attr));
        check("tr_ts", 64'(tr_ts), 64'(exp_q[0].ts));
      end
      check("ovf", 64'(ovf), 64'(m_ovf));
      check("drop_cnt", 64'(drop_cnt), 64'(m_drops));

      do_pop = (occ > 0) && tr_ready;
      if (do_pop) begin
        last_addr_act = tr_addr;
        last_data_act = tr_data;
        last_attr_act = tr_attr;
        void'(exp_q.pop_front());
        n_popped++;
      end

      if (hready) begin
        logic dropped;
        dropped = 1'b0;
        if (outst_q.size() > 0) begin
          phase_t p;
          rec_t   r;
          p = outst_q.pop_front();
          r.addr = p.addr;
          r.data = p.write ? hwdata : hrdata;
          r.attr = {p.info, hresp};
          r.ts   = p.ts;
          if (occ < DEPTH || do_pop) exp_q.push_back(r);
          else dropped = 1'b1;
        end
        if (htrans[1] && cap_en && !(skip_zero && haddr == 32'h0)) begin
          phase_t n;
          n.addr  = haddr;
          n.write = hwrite;
          n.info  = {hwrite, hsize, hburst, hprot, htrans};
`ifdef TRACE_TIMESTAMP_EN
          n.ts    = m_cyc;
`else
          n.ts    = 32'h0;
`endif
          outst_q.push_back(n);
        end
        if (clr) begin
          m_ovf = 1'b0;
          m_drops = 0;
        end else if (dropped) begin
          m_ovf = 1'b1;
          if (m_drops != (1 << CNT_W) - 1) m_drops++;
        end
      end else if (clr) begin
        m_ovf = 1'b0;
        m_drops = 0;
      end
      m_cyc++;
    end
  end

  task automatic cyc(input logic [1:0] tr, input logic [31:0] a, input logic w,
                     input logic [31:0] wd, input logic [31:0] rd, input logic rdy,
                     input logic rsp);
    htrans = tr; haddr = a; hwrite = w; hwdata = wd; hrdata = rd; hready = rdy; hresp = rsp;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(2'b00, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    int p0;
    repeat (3) @(posedge clk);
    #1;
    rst_b = 1'b1;
    idle(2);

    // single write, zero wait states
    p0 = n_popped;
    cyc(2'b10, 32'h2000_0010, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0);
    cyc(2'b00, 32'h0, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0);
    idle(3);
    check("wr_count", 64'(n_popped - p0), 64'(1));
    check("wr_addr", 64'(last_addr_act), 64'(32'h2000_0010));
    check("wr_data", 64'(last_data_act), 64'(32'hDEAD_BEEF));
    check("wr_attr_write", 64'(last_attr_act[13]), 64'(1'b1));
    check("wr_attr_err", 64'(last_attr_act[0]), 64'(1'b0));

    // read with three wait states
    p0 = n_popped;
    cyc(2'b10, 32'h1000_0004, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(2'b00, 32'h0, 1'b0, 32'h0, 32'hFFFF_0000, 1'b0, 1'b0);
    cyc(2'b00, 32'h0, 1'b0, 32'h0, 32'h1234_5678, 1'b1, 1'b0);
    idle(3);
    check("rd_count", 64'(n_popped - p0), 64'(1));
    check("rd_data", 64'(last_data_act), 64'(32'h1234_5678));

    // INCR4 burst from address 0, with and without skip_zero
    hburst = 3'b011;
    for (int s = 1; s >= 0; s--) begin
      skip_zero = s[0];
      p0 = n_popped;
      cyc(2'b10, 32'h0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0);
      for (int k = 1; k < 4; k++)
        cyc(2'b11, 32'(4 * k), 1'b1, 32'(32'hB000_0000 + k - 1), 32'h0, 1'b1, 1'b0);
      cyc(2'b00, 32'h0, 1'b0, 32'hB000_0003, 32'h0, 1'b1, 1'b0);
      idle(4);
      check(s ? "burst_skip_count" : "burst_noskip_count", 64'(n_popped - p0), 64'(s ? 3 : 4));
      check("burst_last_addr", 64'(last_addr_act), 64'(32'hC));
    end
    skip_zero = 1'b0;
    hburst = 3'd0;

    // overflow with downstream stalled
    tr_ready = 1'b0;
    p0 = n_popped;
    for (int i = 0; i < 18; i++)
      cyc(2'b10, 32'(32'h3000_0000 + 4 * i), 1'b1, 32'(32'h5500_0000 + i - 1), 32'h0, 1'b1, 1'b0);
    cyc(2'b00, 32'h0, 1'b0, 32'h5500_0011, 32'h0, 1'b1, 1'b0);
    check("ovf_set", 64'(ovf), 64'(1'b1));
    check("ovf_drop_cnt", 64'(drop_cnt), 64'(16'd2));
    check("ovf_full_valid", 64'(tr_valid), 64'(1'b1));

    // full FIFO with simultaneous push and pop
    cyc(2'b10, 32'h3000_0100, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0);
    tr_ready = 1'b1;
    cyc(2'b00, 32'h0, 1'b0, 32'hA5A5_A5A5, 32'h0, 1'b1, 1'b0);
    tr_ready = 1'b0;
    check("pushpop_drop_cnt", 64'(drop_cnt), 64'(16'd2));

    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    check("clr_ovf", 64'(ovf), 64'(1'b0));
    check("clr_drop_cnt", 64'(drop_cnt), 64'(16'd0));

    tr_ready = 1'b1;
    idle(25);
    check("drain_count", 64'(n_popped - p0), 64'(17));
    check("drain_last_addr", 64'(last_addr_act), 64'(32'h3000_0100));
    check("drain_last_data", 64'(last_data_act), 64'(32'hA5A5_A5A5));

    // two-cycle ERROR response on a read
    cyc(2'b10, 32'h4000_0000, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cyc(2'b00, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cyc(2'b00, 32'h0, 1'b0, 32'h0, 32'hCAFE_0001, 1'b1, 1'b1);
    idle(3);
    check("err_addr", 64'(last_addr_act), 64'(32'h4000_0000));
    check("err_bit", 64'(last_attr_act[0]), 64'(1'b1));

    // asynchronous reset while a read is in a wait state
    p0 = n_popped;
    cyc(2'b10, 32'h5000_0000, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cyc(2'b00, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst_b = 1'b0;
    cyc(2'b00, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(2'b00, 32'h0, 1'b0, 32'h0, 32'h7777_7777, 1'b1, 1'b0);
    rst_b = 1'b1;
    idle(5);
    check("rst_no_record", 64'(n_popped - p0), 64'(0));
    check("rst_valid_low", 64'(tr_valid), 64'(1'b0));

    // randomized traffic; the second half stalls downstream to force drops
    for (int i = 0; i < 600; i++) begin
      htrans    = 2'($urandom_range(0, 3));
      haddr     = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom() & 32'hFFFF_FFFC);
      hwrite    = 1'($urandom_range(0, 1));
      hsize     = 3'($urandom_range(0, 7));
      hburst    = 3'($urandom_range(0, 7));
      hprot     = 4'($urandom_range(0, 15));
      hwdata    = $urandom();
      hrdata    = $urandom();
      hready    = ($urandom_range(0, 3) != 0);
      hresp     = ($urandom_range(0, 7) == 0);
      cap_en    = ($urandom_range(0, 9) != 0);
      skip_zero = 1'($urandom_range(0, 1));
      clr       = ($urandom_range(0, 49) == 0);
      tr_ready  = (i < 350) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
      @(posedge clk);
      #1;
    end
    clr = 1'b0;
    cap_en = 1'b1;
    tr_ready = 1'b1;
    idle(30);
    check("final_empty", 64'(tr_valid), 64'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
